// File: rtl/scr1_arch_types_pkg.sv
// Shared memory-interface types plus the pipeline memory arbiter FSM states and limits.
package scr1_arch_types;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10,
        SCR1_MEM_RESP_ERROR  = 2'b11
    } type_scr1_mem_resp_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } type_scr1_mem_arb_fsm_e;

    localparam int SCR1_MEM_ARB_NCH_MAX   = 8;
    localparam int SCR1_MEM_ARB_OUTST_MAX = 4;

endpackage

// File: rtl/scr1_pipe_mem_arb_fifo.sv
// Owner FIFO: remembers which channel owns each outstanding request, oldest at the head.
module scr1_pipe_mem_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Guards keep the count from wrapping even if a caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scr1_pipe_mem_arb.sv
// N-channel pipeline memory arbiter with in-order response routing.
// Define SCR1_MEM_ARB_RR_EN for round-robin arbitration; fixed priority (ch0 highest) otherwise.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_pipe_mem_arb
    import scr1_arch_types::*;
#(
    parameter int NCH   = 2,
    parameter int OUTST = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                ch2arb_req_i,
    input  type_scr1_mem_cmd_e            ch2arb_cmd_i   [NCH],
    input  type_scr1_mem_width_e          ch2arb_width_i [NCH],
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  ch2arb_addr_i  [NCH],
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  ch2arb_wdata_i [NCH],
    output logic [NCH-1:0]                arb2ch_req_ack_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  arb2ch_rdata_o [NCH],
    output type_scr1_mem_resp_e           arb2ch_resp_o  [NCH],
    output logic                          arb2mem_req_o,
    output type_scr1_mem_cmd_e            arb2mem_cmd_o,
    output type_scr1_mem_width_e          arb2mem_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  arb2mem_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  arb2mem_wdata_o,
    input  logic                          mem2arb_req_ack_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  mem2arb_rdata_i,
    input  type_scr1_mem_resp_e           mem2arb_resp_i,
    output type_scr1_mem_arb_fsm_e        dbg_arb_state_o
);

    // Handshake: a request is accepted on a cycle with req && req_ack both high; the requestor
    // holds req and its fields stable until then. A response cycle is any resp != NOTRDY.

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    type_scr1_mem_arb_fsm_e arb_state;
    logic [IW-1:0]          lock_idx;
    logic [IW-1:0]          sel_idx;
    logic                   sel_vld;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_vld;
    logic                   accept;
    logic                   resp_vld;
    logic [IW-1:0]          fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;

`ifdef SCR1_MEM_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    // Scan downwards so the channel closest to rr_ptr is written last and wins.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            logic [IW-1:0] c;
            c = IW'((int'(rr_ptr) + k) % NCH);
            if (ch2arb_req_i[c]) begin
                sel_idx = c;
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      rr_ptr <= '0;
        else if (accept) rr_ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
    end
`else
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch2arb_req_i[IW'(k)]) begin
                sel_idx = IW'(k);
                sel_vld = 1'b1;
            end
        end
    end
`endif

    assign gnt_idx  = (arb_state == ARB_LOCK) ? lock_idx : sel_idx;
    assign gnt_vld  = rst_n & ((arb_state == ARB_LOCK) | (sel_vld & ~fifo_full));
    assign accept   = gnt_vld & mem2arb_req_ack_i;
    assign resp_vld = rst_n & ~fifo_empty & (mem2arb_resp_i != SCR1_MEM_RESP_NOTRDY);
    assign dbg_arb_state_o = arb_state;

    // A stalled winner is pinned in ARB_LOCK so no later request can overtake it downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_state <= ARB_IDLE;
            lock_idx  <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (gnt_vld && !mem2arb_req_ack_i) begin
                        arb_state <= ARB_LOCK;
                        lock_idx  <= sel_idx;
                    end
                end
                ARB_LOCK: begin
                    if (mem2arb_req_ack_i) arb_state <= ARB_IDLE;
                end
                default: arb_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        arb2mem_req_o    = gnt_vld;
        arb2mem_cmd_o    = SCR1_MEM_CMD_RD;
        arb2mem_width_o  = SCR1_MEM_WIDTH_BYTE;
        arb2mem_addr_o   = '0;
        arb2mem_wdata_o  = '0;
        arb2ch_req_ack_o = '0;
        if (gnt_vld) begin
            arb2mem_cmd_o             = ch2arb_cmd_i[gnt_idx];
            arb2mem_width_o           = ch2arb_width_i[gnt_idx];
            arb2mem_addr_o            = ch2arb_addr_i[gnt_idx];
            arb2mem_wdata_o           = ch2arb_wdata_i[gnt_idx];
            arb2ch_req_ack_o[gnt_idx] = mem2arb_req_ack_i;
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            arb2ch_rdata_o[k] = '0;
            arb2ch_resp_o[k]  = SCR1_MEM_RESP_NOTRDY;
        end
        if (resp_vld) begin
            arb2ch_rdata_o[fifo_head] = mem2arb_rdata_i;
            arb2ch_resp_o[fifo_head]  = mem2arb_resp_i;
        end
    end

    scr1_pipe_mem_arb_fifo #(
        .DEPTH (OUTST),
        .WIDTH (IW)
    ) i_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (gnt_idx),
        .pop       (resp_vld),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
